// File: rtl/edge_detector_multi.sv
`default_nettype none
// ============================================================================
// Module   : edge_detector_multi
// Purpose  : Multi-channel synchronising, debouncing edge detector for
//            asynchronous inputs such as strobes, buttons and status pins.
//            Each channel has a synchroniser chain and a stability filter.
//            It produces rising/falling pulses of the filtered level, and a
//            mode-selected event that drives a sticky flag and a saturating
//            counter. irq is the OR of all sticky flags.
// Ports    : clk     - clock
//            rst_n   - asynchronous active-low reset
//            in      - raw asynchronous inputs, bit i = channel i
//            mode    - per-channel event select [2i+1:2i]
//                      (00 none, 01 rise, 10 fall, 11 both)
//            clear   - synchronous clear of channel sticky flag and counter
//            level   - filtered level per channel
//            out_re  - one-cycle rising pulse of the filtered level
//            out_fe  - one-cycle falling pulse of the filtered level
//            flag    - sticky flag, a selected event occurred since clear
//            count   - saturating event count, CNT_W bits per channel
//            irq     - OR of all flag bits
// Revision : 1.0 - initial release
// ============================================================================
module edge_detector_multi #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       out_re,
  output logic [CHANNELS-1:0]       out_fe,
  output logic [CHANNELS-1:0]       flag,
  output logic [CNT_W*CHANNELS-1:0] count,
  output logic                      irq
);

  // One extra bit keeps the counter well-formed when FILTER_CYCLES is 1.
  localparam int             FC_W       = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FC_W-1:0] C_FC_LAST = FC_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [CHANNELS-1:0] r_filt;
  logic [CHANNELS-1:0] r_filt_d;
  logic [CHANNELS-1:0] r_flag;
  logic [CHANNELS-1:0] w_ev;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [FC_W-1:0]        r_fc;
      logic [CNT_W-1:0]       r_cnt;
      logic                   w_s;

      assign w_s = r_sync[SYNC_STAGES-1];

      // Plain shift chain, no logic between stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], in[i]};
        end
      end

      // The filtered level only follows the synchronised input after it
      // has disagreed for FILTER_CYCLES consecutive cycles. Any agreement
      // in between restarts the count, so short glitches are dropped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_fc       <= '0;
          r_filt[i]  <= 1'b0;
        end else if (w_s == r_filt[i]) begin
          r_fc       <= '0;
        end else if (r_fc == C_FC_LAST) begin
          r_filt[i]  <= w_s;
          r_fc       <= '0;
        end else begin
          r_fc       <= r_fc + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_filt_d[i] <= 1'b0;
        end else begin
          r_filt_d[i] <= r_filt[i];
        end
      end

      assign out_re[i] = r_filt[i] & ~r_filt_d[i];
      assign out_fe[i] = ~r_filt[i] & r_filt_d[i];
      assign w_ev[i]   = (mode[2*i] & out_re[i]) | (mode[2*i+1] & out_fe[i]);

      // An event coinciding with clear wins, so no event is ever lost.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_flag[i] <= 1'b0;
        end else if (w_ev[i]) begin
          r_flag[i] <= 1'b1;
        end else if (clear[i]) begin
          r_flag[i] <= 1'b0;
        end
      end

      // Clear restarts the count; a coincident event is counted as the first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clear[i]) begin
          r_cnt <= w_ev[i] ? CNT_W'(1) : '0;
        end else if (w_ev[i] && (r_cnt != C_CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign count[CNT_W*i +: CNT_W] = r_cnt;
    end
  endgenerate

  assign level = r_filt;
  assign flag  = r_flag;
  assign irq   = |r_flag;

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_detector_multi
// Purpose  : Directed self-checking bench for edge_detector_multi
//            (4 channels, 2 sync stages, 4 filter cycles, 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_detector_multi;

  localparam int CH    = 4;
  localparam int CNT_W = 2;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     in;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     clear;
  logic [CH-1:0]     level;
  logic [CH-1:0]     out_re;
  logic [CH-1:0]     out_fe;
  logic [CH-1:0]     flag;
  logic [CNT_W*CH-1:0] count;
  logic              irq;

  int checks;
  int errors;

  edge_detector_multi #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (4),
    .CNT_W         (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .mode   (mode),
    .clear  (clear),
    .level  (level),
    .out_re (out_re),
    .out_fe (out_fe),
    .flag   (flag),
    .count  (count),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; returns 1ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    logic [CNT_W*CH-1:0] c;
    c = count;
    return 32'(c[CNT_W*ch +: CNT_W]);
  endfunction

  int re_seen, fe_seen, lvl_seen, n_re, n_fe;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    in     = '0;
    clear  = '0;
    mode   = {2'b11, 2'b10, 2'b11, 2'b01};
    tick(3);

    check_val("rst_level",  32'(level),  32'h0);
    check_val("rst_out_re", 32'(out_re), 32'h0);
    check_val("rst_out_fe", 32'(out_fe), 32'h0);
    check_val("rst_flag",   32'(flag),   32'h0);
    check_val("rst_count",  32'(count),  32'h0);
    check_val("rst_irq",    32'(irq),    32'h0);

    rst_n = 1'b1;
    tick(3);

    // Channel 0 rising, mode rise: pulse after edge 6
    in[0] = 1'b1;
    tick(5);
    check_val("ch0_level_early", 32'(level[0]),  32'h0);
    check_val("ch0_re_early",    32'(out_re),    32'h0);
    tick(1);
    check_val("ch0_re_pulse",    32'(out_re),    32'h1);
    check_val("ch0_level",       32'(level[0]),  32'h1);
    check_val("ch0_fe_quiet",    32'(out_fe),    32'h0);
    tick(1);
    check_val("ch0_re_oneshot",  32'(out_re),    32'h0);
    check_val("ch0_flag",        32'(flag),      32'h1);
    check_val("ch0_count",       cnt_of(0),      32'h1);
    check_val("ch0_irq",         32'(irq),       32'h1);

    // Channel 1: 3-cycle glitch is rejected
    re_seen = 0; fe_seen = 0; lvl_seen = 0;
    in[1] = 1'b1;
    repeat (3) begin
      tick(1);
      re_seen |= int'(out_re[1]); fe_seen |= int'(out_fe[1]); lvl_seen |= int'(level[1]);
    end
    in[1] = 1'b0;
    repeat (12) begin
      tick(1);
      re_seen |= int'(out_re[1]); fe_seen |= int'(out_fe[1]); lvl_seen |= int'(level[1]);
    end
    check_val("ch1_glitch_level", 32'(lvl_seen), 32'h0);
    check_val("ch1_glitch_re",    32'(re_seen),  32'h0);
    check_val("ch1_glitch_fe",    32'(fe_seen),  32'h0);
    check_val("ch1_glitch_flag",  32'(flag[1]),  32'h0);

    // Channel 2, mode fall: both pulses appear, only the fall is an event
    n_re = 0; n_fe = 0;
    in[2] = 1'b1;
    repeat (10) begin
      tick(1);
      n_re += int'(out_re[2]); n_fe += int'(out_fe[2]);
    end
    check_val("ch2_re_count",   32'(n_re),    32'h1);
    check_val("ch2_flag_rise",  32'(flag[2]), 32'h0);
    check_val("ch2_count_rise", cnt_of(2),    32'h0);
    in[2] = 1'b0;
    repeat (10) begin
      tick(1);
      n_re += int'(out_re[2]); n_fe += int'(out_fe[2]);
    end
    check_val("ch2_fe_count",   32'(n_fe),    32'h1);
    check_val("ch2_re_total",   32'(n_re),    32'h1);
    check_val("ch2_flag_fall",  32'(flag[2]), 32'h1);
    check_val("ch2_count_fall", cnt_of(2),    32'h1);

    // Channel 3, mode both: 10 edges saturate the 2-bit counter at 3
    repeat (10) begin
      in[3] = ~in[3];
      tick(8);
    end
    check_val("ch3_count_sat", cnt_of(3),    32'h3);
    check_val("ch3_flag",      32'(flag[3]), 32'h1);
    in[3] = 1'b1;
    tick(6);
    check_val("ch3_re_pulse",  32'(out_re[3]), 32'h1);
    clear[3] = 1'b1;
    tick(1);
    clear = '0;
    check_val("ch3_clr_ev_flag",  32'(flag[3]), 32'h1);
    check_val("ch3_clr_ev_count", cnt_of(3),    32'h1);
    clear[3] = 1'b1;
    tick(1);
    clear = '0;
    check_val("ch3_clr_flag",  32'(flag[3]), 32'h0);
    check_val("ch3_clr_count", cnt_of(3),    32'h0);

    // All channels, mode both, toggled together
    mode = '1;
    in   = '0;
    tick(10);
    clear = '1;
    tick(1);
    clear = '0;
    check_val("all_pre_flag", 32'(flag), 32'h0);
    check_val("all_pre_irq",  32'(irq),  32'h0);
    in = '1;
    tick(6);
    check_val("all_re",    32'(out_re), 32'hF);
    tick(1);
    check_val("all_flag",  32'(flag),   32'hF);
    check_val("all_irq",   32'(irq),    32'h1);
    check_val("all_count", 32'(count),  32'h55);
    clear = '1;
    tick(1);
    clear = '0;
    check_val("all_clr_flag", 32'(flag), 32'h0);
    check_val("all_clr_irq",  32'(irq),  32'h0);

    // Reset in the middle of a pending filtered transition
    in = '0;
    tick(10);
    check_val("pre_rst_flag",  32'(flag),  32'hF);
    check_val("pre_rst_count", 32'(count), 32'h55);
    in = 4'b0001;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_level", 32'(level),  32'h0);
    check_val("midrst_flag",  32'(flag),   32'h0);
    check_val("midrst_count", 32'(count),  32'h0);
    check_val("midrst_irq",   32'(irq),    32'h0);
    check_val("midrst_re",    32'(out_re), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check_val("post_rst_re_early",    32'(out_re), 32'h0);
    check_val("post_rst_level_early", 32'(level),  32'h0);
    tick(1);
    check_val("post_rst_re",    32'(out_re), 32'h1);
    tick(1);
    check_val("post_rst_re_end", 32'(out_re), 32'h0);
    check_val("post_rst_level",  32'(level),  32'h1);
    check_val("post_rst_flag",   32'(flag),   32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
